uart_tx_arbiter: RTL and testbench

Shares one UART transmitter among NUM_REQ byte-stream requesters (console, status reporter, loopback echo, debug). Round-robin arbitration with packet locking: a granted requester keeps the transmitter until it marks its last byte or hits MAX_BURST bytes. Honours the far end's UARTn_CTS handshake and sequences the transmitter through its tx_start/tx_busy interface.

---
 rtl/uart_tx_arbiter.sv | 152 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte streams: round-robin grant,
// packet locking with a burst limit, CTS flow control and tx_start/tx_busy sequencing.
//   state       | meaning
//   S_IDLE      | waiting for a request with CTS high and the transmitter idle
//   S_SEND      | one-cycle tx_start/gnt pulse for the captured byte
//   S_WAIT_BUSY | waiting for the transmitter to raise tx_busy
//   S_WAIT_DONE | byte in flight; on completion continue the packet or release
module uart_tx_arbiter #(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_W    = 8,
  parameter  int MAX_BURST = 16,
  localparam int OW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        gnt,
  input  logic                      UARTn_CTS,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [OW-1:0]             owner,
  output logic                      locked
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SEND      = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  localparam logic [7:0]    MAX_B    = 8'(MAX_BURST);
  localparam logic [OW-1:0] LAST_IDX = OW'(NUM_REQ - 1);

  state_t              state_q, state_d;
  logic [OW-1:0]       owner_q, owner_d;
  logic [OW-1:0]       rr_q, rr_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic [7:0]          burst_cnt_q, burst_cnt_d;
  logic                locked_q, locked_d;
  logic                tx_start_q, tx_start_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;

  logic [DATA_W-1:0]   req_byte [NUM_REQ];
  logic [OW-1:0]       scan_idx, win_idx, cap_idx, owner_inc;
  logic                win_found, do_capture;
  logic [7:0]          cap_cnt;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_byte[i] = req_data[i*DATA_W +: DATA_W];
  end

  // First requester at or after the rr pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_q;
    scan_idx  = rr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = OW'((int'(rr_q) + k) % NUM_REQ);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  assign owner_inc = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    tx_data_d   = tx_data_q;
    burst_cnt_d = burst_cnt_q;
    locked_d    = locked_q;
    tx_start_d  = 1'b0;
    gnt_d       = '0;
    do_capture  = 1'b0;
    cap_idx     = owner_q;
    cap_cnt     = burst_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (win_found && UARTn_CTS && !tx_busy) begin
          do_capture = 1'b1;
          cap_idx    = win_idx;
          cap_cnt    = 8'd1;
        end
      end
      S_SEND: state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (tx_busy) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          // Release rotates the pointer even on a forced burst-limit release.
          if (!locked_q || !req[owner_q]) begin
            locked_d = 1'b0;
            rr_d     = owner_inc;
            state_d  = S_IDLE;
          end else if (UARTn_CTS) begin
            do_capture = 1'b1;
            cap_cnt    = burst_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (do_capture) begin
      owner_d        = cap_idx;
      tx_data_d      = req_byte[cap_idx];
      burst_cnt_d    = cap_cnt;
      locked_d       = !req_last[cap_idx] && (cap_cnt < MAX_B);
      tx_start_d     = 1'b1;
      gnt_d[cap_idx] = 1'b1;
      state_d        = S_SEND;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      rr_q        <= '0;
      tx_data_q   <= '0;
      burst_cnt_q <= '0;
      locked_q    <= 1'b0;
      tx_start_q  <= 1'b0;
      gnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      tx_data_q   <= tx_data_d;
      burst_cnt_q <= burst_cnt_d;
      locked_q    <= locked_d;
      tx_start_q  <= tx_start_d;
      gnt_q       <= gnt_d;
    end
  end

  assign gnt      = gnt_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign owner    = owner_q;
  assign locked   = locked_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scenarios followed by randomized traffic checked against a
// transaction-level round-robin/packet-lock model of the arbiter.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int N    = 4;
  localparam int MAXB = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*8-1:0]  req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    gnt;
  logic            cts;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            tx_busy;
  logic [1:0]      owner;
  logic            locked;

  int n_checks = 0;
  int n_errors = 0;

  // transmitter model configuration (written by the main sequence)
  int tx_len_cfg = 10;
  int tx_dly_cfg = 0;

  // random-phase requester and model state
  logic [7:0] cur_data [N];
  logic       cur_last [N];
  int         left     [N];
  int         idle_cnt [N];
  bit         active   [N];
  int         m_rr, m_owner, m_cnt, ew, n_grants, n_starts;
  bit         m_locked, started;
  logic [7:0] st_data;
  logic [N-1:0] rq;
  logic       ok;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(8), .MAX_BURST(MAXB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .req_last  (req_last),
    .gnt       (gnt),
    .UARTn_CTS (cts),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .owner     (owner),
    .locked    (locked)
  );

  always #100 clk = ~clk;

  // Transmitter: after a start pulse waits tx_dly_cfg cycles, then busy for tx_len_cfg cycles.
  initial begin
    bit pend;
    int dly, bcnt;
    pend = 0; dly = 0; bcnt = 0;
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #20;
      if (tx_start) begin
        pend = 1;
        dly  = tx_dly_cfg;
      end else if (pend) begin
        if (dly > 0) dly--;
        else begin
          pend    = 0;
          tx_busy = 1'b1;
          bcnt    = tx_len_cfg;
        end
      end else if (tx_busy) begin
        if (bcnt > 1) bcnt--;
        else tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #(200 * 50000);
    $display("FAIL watchdog: run did not complete, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int i, input logic [7:0] d, input logic l);
    req[i]            = 1'b1;
    req_data[i*8 +: 8] = d;
    req_last[i]       = l;
  endtask

  task automatic do_reset();
    req      = '0;
    req_last = '0;
    req_data = '0;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_start(input string tag, input int budget, output logic got);
    got = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (tx_start) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk({tag, "_timeout"}, 32'(tx_start), 32'd1);
  endtask

  task automatic wait_busy(input string tag, input logic lvl, input int budget);
    bit seen;
    seen = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (tx_busy === lvl) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk({tag, "_busy_timeout"}, 32'(tx_busy), 32'(lvl));
  endtask

  // Waits for a grant, checks it, then checks the pulse is exactly one cycle long.
  task automatic expect_grant(input string tag, input int w, input logic [7:0] d, input logic lk);
    logic got;
    wait_start(tag, 400, got);
    if (got) begin
      chk({tag, "_gnt"},    32'(gnt),     32'(1) << w);
      chk({tag, "_owner"},  32'(owner),   32'(w));
      chk({tag, "_data"},   32'(tx_data), 32'(d));
      chk({tag, "_locked"}, 32'(locked),  32'(lk));
      @(negedge clk);
      chk({tag, "_pulse"},  {27'd0, tx_start, gnt}, 32'd0);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int from);
    for (int k = 0; k < N; k++)
      if (r[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  task automatic new_packet(input int i);
    left[i]     = int'($urandom_range(1, 20));
    cur_data[i] = 8'($urandom);
    cur_last[i] = (left[i] == 1);
    active[i]   = 1;
    put(i, cur_data[i], cur_last[i]);
  endtask

  initial begin
    rst_n = 1'b0; req = '0; req_data = '0; req_last = '0; cts = 1'b1;
    @(negedge clk);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_gnt",      32'(gnt),      32'd0);
    chk("rst_owner",    32'(owner),    32'd0);
    chk("rst_locked",   32'(locked),   32'd0);
    chk("rst_tx_data",  32'(tx_data),  32'd0);
    do_reset();

    // single byte, then pointer must have moved to 3
    put(2, 8'hA5, 1'b1);
    expect_grant("single", 2, 8'hA5, 1'b0);
    req[2] = 1'b0;
    put(1, 8'h31, 1'b1);
    put(3, 8'h33, 1'b1);
    expect_grant("single_rr3", 3, 8'h33, 1'b0);
    req = '0;
    repeat (20) @(negedge clk);

    // round robin with all four held
    do_reset();
    for (int i = 0; i < N; i++) put(i, 8'(8'h10 + i), 1'b1);
    for (int g = 0; g < 5; g++) expect_grant("rrobin", g % N, 8'(8'h10 + (g % N)), 1'b0);
    req = '0;
    repeat (20) @(negedge clk);

    // packet lock
    do_reset();
    put(1, 8'h11, 1'b0);
    expect_grant("lock_b1", 1, 8'h11, 1'b1);
    put(0, 8'h5A, 1'b1);
    put(1, 8'h22, 1'b0);
    expect_grant("lock_b2", 1, 8'h22, 1'b1);
    put(1, 8'h33, 1'b1);
    expect_grant("lock_b3", 1, 8'h33, 1'b0);
    req[1] = 1'b0;
    expect_grant("lock_next", 0, 8'h5A, 1'b0);
    req = '0;
    repeat (20) @(negedge clk);

    // burst limit
    do_reset();
    tx_len_cfg = 3;
    put(3, 8'h80, 1'b0);
    for (int b = 1; b <= MAXB; b++) begin
      expect_grant("burst", 3, 8'(8'h7F + b), 1'(b < MAXB));
      put(3, 8'(8'h80 + b), 1'b0);
      put(0, 8'h0F, 1'b1);
    end
    expect_grant("burst_release", 0, 8'h0F, 1'b0);
    req = '0;
    repeat (20) @(negedge clk);

    // CTS stall
    do_reset();
    tx_len_cfg = 10;
    cts = 1'b0;
    put(2, 8'h21, 1'b0);
    n_starts = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_start) n_starts++;
    end
    chk("cts_block_idle", 32'(n_starts), 32'd0);
    cts = 1'b1;
    expect_grant("cts_b1", 2, 8'h21, 1'b1);
    put(2, 8'h22, 1'b0);
    expect_grant("cts_b2", 2, 8'h22, 1'b1);
    cts = 1'b0;
    put(2, 8'h23, 1'b1);
    wait_busy("cts_b2", 1'b1, 20);
    wait_busy("cts_b2", 1'b0, 50);
    n_starts = 0;
    repeat (10) begin
      @(negedge clk);
      if (tx_start) n_starts++;
    end
    chk("cts_block_lock", 32'(n_starts), 32'd0);
    chk("cts_hold_locked", 32'(locked), 32'd1);
    chk("cts_hold_owner",  32'(owner),  32'd2);
    cts = 1'b1;
    expect_grant("cts_b3", 2, 8'h23, 1'b0);
    req = '0;
    repeat (20) @(negedge clk);

    // reset while waiting for busy; pointer is 3 here and must return to 0
    tx_dly_cfg = 3;
    put(1, 8'h77, 1'b0);
    expect_grant("rst_pre", 1, 8'h77, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_tx_start", 32'(tx_start), 32'd0);
    chk("rstmid_gnt",      32'(gnt),      32'd0);
    chk("rstmid_owner",    32'(owner),    32'd0);
    chk("rstmid_locked",   32'(locked),   32'd0);
    chk("rstmid_tx_data",  32'(tx_data),  32'd0);
    rst_n = 1'b1;
    tx_dly_cfg = 0;
    put(0, 8'h40, 1'b1);
    put(3, 8'h43, 1'b1);
    expect_grant("rst_rearb", 0, 8'h40, 1'b0);
    req = '0;
    repeat (20) @(negedge clk);

    // randomized traffic against the transaction-level model
    do_reset();
    m_rr = 0; m_owner = 0; m_cnt = 0; m_locked = 0; started = 0; n_grants = 0;
    st_data = '0;
    for (int i = 0; i < N; i++) begin
      active[i] = 0; left[i] = 0; cur_data[i] = '0; cur_last[i] = 1'b0;
      idle_cnt[i] = int'($urandom_range(0, 5));
    end
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      ew = -1;
      if (started && tx_busy) chk("rand_data_stable", 32'(tx_data), 32'(st_data));
      if (tx_start) begin
        rq = req;
        ew = m_locked ? m_owner : rr_pick(rq, m_rr);
        if (ew < 0) chk("rand_spurious_gnt", 32'(gnt), 32'd0);
        else begin
          chk("rand_gnt",     32'(gnt),     32'(1) << ew);
          chk("rand_owner",   32'(owner),   32'(ew));
          chk("rand_data",    32'(tx_data), 32'(cur_data[ew]));
          chk("rand_busy_at_gnt", 32'(tx_busy), 32'd0);
          m_cnt    = m_locked ? m_cnt + 1 : 1;
          m_owner  = ew;
          m_locked = !cur_last[ew] && (m_cnt < MAXB);
          if (!m_locked) m_rr = (ew + 1) % N;
          chk("rand_locked",  32'(locked),  32'(m_locked));
          st_data = cur_data[ew];
          started = 1;
          n_grants++;
          left[ew]--;
          if (left[ew] > 0) begin
            cur_data[ew] = 8'($urandom);
            cur_last[ew] = (left[ew] == 1);
            put(ew, cur_data[ew], cur_last[ew]);
          end else begin
            active[ew]   = 0;
            req[ew]      = 1'b0;
            idle_cnt[ew] = int'($urandom_range(0, 8));
          end
          tx_len_cfg = int'($urandom_range(1, 6));
          tx_dly_cfg = int'($urandom_range(0, 2));
        end
      end else begin
        chk("rand_gnt_without_start", 32'(gnt), 32'd0);
      end
      for (int i = 0; i < N; i++) begin
        if (i != ew && !active[i]) begin
          if (idle_cnt[i] > 0) idle_cnt[i]--;
          else new_packet(i);
        end
      end
      cts = ($urandom_range(0, 7) != 0);
    end
    chk("rand_enough_grants", 32'(n_grants >= 100), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
